streaming_fifo_param: RTL and testbench

Parametrised streaming FIFO for AXI-Stream dataflow between compute layers. It carries arbitrary-width words with exact DEPTH capacity and first-word-fall-through output. It also provides an occupancy count, almost-full/almost-empty flags and a synchronous flush. It sits between adjacent layer stages wherever the dataflow graph inserts a buffering FIFO.

---
 rtl/streaming_fifo_param.sv | 153 +++++++++++++++
 tb/tb_streaming_fifo_param.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/streaming_fifo_param.sv
// rtl/streaming_fifo_param.sv - parametrised first-word-fall-through streaming FIFO
//
// Purpose: buffers a TDATA/TVALID/TREADY stream between two compute stages.
//   Storage is a RAM of DEPTH-1 words plus one output register, giving an exact
//   capacity of DEPTH words for any DEPTH >= 2 (not just powers of two).
//   The output register doubles as the RAM's synchronous read register, so the
//   head word is always presented on out_V_TDATA without a bubble.
//
// Ports:
//   ap_clk        sole clock, rising edge
//   ap_rst        synchronous active-high reset
//   flush         synchronous discard of all contents (wins over push/pop)
//   count         occupancy in words, output register included
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   in0_V_*       upstream stream (TDATA/TVALID/TREADY)
//   out_V_*       downstream stream (TDATA/TVALID/TREADY)
//   max_count     peak occupancy, only with STREAMING_FIFO_WMARK_EN defined
//
// Optional feature macro: STREAMING_FIFO_WMARK_EN (adds max_count watermark).
module streaming_fifo_param #(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 16384,
  parameter  int AF_THRESH = DEPTH - 2,
  parameter  int AE_THRESH = 2,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             almost_empty,
  input  logic [WIDTH-1:0] in0_V_TDATA,
  input  logic             in0_V_TVALID,
  output logic             in0_V_TREADY,
  output logic [WIDTH-1:0] out_V_TDATA,
  output logic             out_V_TVALID,
  input  logic             out_V_TREADY
`ifdef STREAMING_FIFO_WMARK_EN
  ,
  output logic [CW-1:0]    max_count
`endif
);

  // RAM holds everything except the head word, which lives in r_data.
  localparam int RD = DEPTH - 1;
  localparam int PW = (RD > 1) ? $clog2(RD) : 1;

  logic [WIDTH-1:0] r_ram [RD];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  logic             w_push;
  logic             w_pop;
  logic             w_out_free;
  logic             w_ram_empty;
  logic             w_load_ram;
  logic             w_bypass;
  logic             w_ram_wr;
  logic [CW-1:0]    w_ram_count;
  logic [CW-1:0]    w_count_next;
  logic [PW-1:0]    w_wr_ptr_inc;
  logic [PW-1:0]    w_rd_ptr_inc;

  // Ready depends only on registered occupancy; the reset gating is the one
  // intentional input-to-output path.
  assign in0_V_TREADY = (r_count != CW'(DEPTH)) && !ap_rst;

  assign w_push = in0_V_TVALID && in0_V_TREADY;
  assign w_pop  = r_valid && out_V_TREADY;

  // Words sitting in the RAM: total occupancy minus the head register.
  assign w_ram_count = r_count - CW'(r_valid);
  assign w_ram_empty = (w_ram_count == '0);

  // The head register can accept a new word when it is empty or being popped.
  // Refill from RAM if it holds anything, otherwise take the pushed word
  // directly so an empty FIFO still has one-cycle latency.
  assign w_out_free = !r_valid || w_pop;
  assign w_load_ram = w_out_free && !w_ram_empty;
  assign w_bypass   = w_out_free && w_ram_empty && w_push;
  assign w_ram_wr   = w_push && !w_bypass;

  // Explicit wrap at RD-1 so any DEPTH works, not only powers of two.
  assign w_wr_ptr_inc = (r_wr_ptr == PW'(RD - 1)) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_ptr_inc = (r_rd_ptr == PW'(RD - 1)) ? '0 : r_rd_ptr + PW'(1);

  assign w_count_next = flush ? '0 : (r_count + CW'(w_push) - CW'(w_pop));

  // Storage array kept free of reset so it can map onto block RAM.
  always_ff @(posedge ap_clk) begin
    if (w_ram_wr && !flush) begin
      r_ram[r_wr_ptr] <= in0_V_TDATA;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else if (flush) begin
      // Head data is left as-is; TVALID low makes it meaningless.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (w_ram_wr) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (w_load_ram) begin
        r_data   <= r_ram[r_rd_ptr];
        r_rd_ptr <= w_rd_ptr_inc;
        r_valid  <= 1'b1;
      end else if (w_bypass) begin
        r_data  <= in0_V_TDATA;
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign count        = r_count;
  assign out_V_TDATA  = r_data;
  assign out_V_TVALID = r_valid;
  assign almost_full  = (r_count >= CW'(AF_THRESH));
  assign almost_empty = (r_count <= CW'(AE_THRESH));

`ifdef STREAMING_FIFO_WMARK_EN
  // Peak occupancy; survives flush, cleared only by reset.
  logic [CW-1:0] r_max_count;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_max_count <= '0;
    end else if (w_count_next > r_max_count) begin
      r_max_count <= w_count_next;
    end
  end

  assign max_count = r_max_count;
`endif

endmodule

// File: tb/tb_streaming_fifo_param.sv
// tb/tb_streaming_fifo_param.sv - randomized queue-model bench for streaming_fifo_param
module tb_streaming_fifo_param;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int D5 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         flush;
  logic [W-1:0] din;
  logic         vin;
  logic         rdy_out;
  logic [4:0]   count;
  logic         af;
  logic         ae;
  logic         in_rdy;
  logic [W-1:0] dout;
  logic         ov;

  logic         flush5;
  logic [W-1:0] din5;
  logic         vin5;
  logic         rdy5;
  logic [2:0]   count5;
  logic         af5;
  logic         ae5;
  logic         in_rdy5;
  logic [W-1:0] dout5;
  logic         ov5;

`ifdef STREAMING_FIFO_WMARK_EN
  logic [4:0]   mc;
  logic [2:0]   mc5;
`endif

  streaming_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_THRESH(14), .AE_THRESH(2)) u_dut16 (
    .ap_clk(clk), .ap_rst(rst), .flush(flush), .count(count),
    .almost_full(af), .almost_empty(ae),
    .in0_V_TDATA(din), .in0_V_TVALID(vin), .in0_V_TREADY(in_rdy),
    .out_V_TDATA(dout), .out_V_TVALID(ov), .out_V_TREADY(rdy_out)
`ifdef STREAMING_FIFO_WMARK_EN
    , .max_count(mc)
`endif
  );

  streaming_fifo_param #(.WIDTH(W), .DEPTH(D5)) u_dut5 (
    .ap_clk(clk), .ap_rst(rst), .flush(flush5), .count(count5),
    .almost_full(af5), .almost_empty(ae5),
    .in0_V_TDATA(din5), .in0_V_TVALID(vin5), .in0_V_TREADY(in_rdy5),
    .out_V_TDATA(dout5), .out_V_TVALID(ov5), .out_V_TREADY(rdy5)
`ifdef STREAMING_FIFO_WMARK_EN
    , .max_count(mc5)
`endif
  );

  int errors = 0;
  int checks = 0;
  bit done   = 0;

  // Reference model: plain queues of words, updated on each rising edge.
  logic [W-1:0] q16[$];
  logic [W-1:0] q5[$];
  int           mx16 = 0;
  int           mx5  = 0;

  always @(posedge clk) begin
    bit pop_m;
    bit push_m;
    if (rst) begin
      q16.delete();
      mx16 = 0;
    end else if (flush) begin
      q16.delete();
    end else begin
      pop_m  = (q16.size() > 0) && rdy_out;
      push_m = vin && (q16.size() != D);
      if (pop_m) void'(q16.pop_front());
      if (push_m) q16.push_back(din);
    end
    if (q16.size() > mx16) mx16 = q16.size();

    if (rst) begin
      q5.delete();
      mx5 = 0;
    end else if (flush5) begin
      q5.delete();
    end else begin
      pop_m  = (q5.size() > 0) && rdy5;
      push_m = vin5 && (q5.size() != D5);
      if (pop_m) void'(q5.pop_front());
      if (push_m) q5.push_back(din5);
    end
    if (q5.size() > mx5) mx5 = q5.size();
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = q16.size();
    check_eq("count16", 32'(count), n);
    check_eq("tvalid16", 32'(ov), 32'(n > 0));
    if (n > 0) check_eq("tdata16", 32'(dout), 32'(q16[0]));
    check_eq("tready16", 32'(in_rdy), 32'((n != D) && !rst));
    check_eq("afull16", 32'(af), 32'(n >= 14));
    check_eq("aempty16", 32'(ae), 32'(n <= 2));
    n = q5.size();
    check_eq("count5", 32'(count5), n);
    check_eq("tvalid5", 32'(ov5), 32'(n > 0));
    if (n > 0) check_eq("tdata5", 32'(dout5), 32'(q5[0]));
    check_eq("tready5", 32'(in_rdy5), 32'((n != D5) && !rst));
    check_eq("afull5", 32'(af5), 32'(n >= 3));
    check_eq("aempty5", 32'(ae5), 32'(n <= 2));
`ifdef STREAMING_FIFO_WMARK_EN
    check_eq("maxcnt16", 32'(mc), mx16);
    check_eq("maxcnt5", 32'(mc5), mx5);
`endif
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
  endtask

  // DEPTH=5 instance: 1000 words of continuous streaming, then random traffic.
  initial begin
    logic [W-1:0] seq;
    seq = 8'h00;
    flush5 = 1'b0; vin5 = 1'b1; rdy5 = 1'b1; din5 = seq;
    @(negedge clk);
    while (rst) @(negedge clk);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!rst && in_rdy5) seq = seq + 8'd1;
      din5 = seq;
    end
    while (!done) begin
      @(negedge clk);
      vin5   = 1'($urandom_range(0, 1));
      rdy5   = 1'($urandom_range(0, 1));
      din5   = 8'($urandom);
      flush5 = ($urandom_range(0, 99) == 0);
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; vin = 1'b0; din = '0; rdy_out = 1'b0;
    tick(); tick();
    check_eq("rst_tdata", 32'(dout), 32'h0);
    rst = 1'b0;
    tick();

    // Fill to full with downstream stalled, then one blocked push attempt.
    for (int i = 0; i < D; i++) begin
      vin = 1'b1; din = 8'(i);
      tick();
    end
    din = 8'h77;
    tick();
    vin = 1'b0;

    // Drain back-to-back.
    rdy_out = 1'b1;
    repeat (D + 1) tick();
    rdy_out = 1'b0;

    // Refill, then push and pop together at the full boundary.
    for (int i = 0; i < D; i++) begin
      vin = 1'b1; din = 8'(8'h40 + i);
      tick();
    end
    din = 8'h99; rdy_out = 1'b1;
    tick();
    vin = 1'b0; rdy_out = 1'b0;
    tick();

    // Drain to 7, then flush while a push is offered.
    rdy_out = 1'b1;
    repeat (8) tick();
    rdy_out = 1'b0;
    flush = 1'b1; vin = 1'b1; din = 8'hEE;
    tick();
    flush = 1'b0; vin = 1'b0;
    rdy_out = 1'b1;
    repeat (3) tick();
    rdy_out = 1'b0;

    // Mid-stream reset at count 9, then a single push after release.
    for (int i = 0; i < 9; i++) begin
      vin = 1'b1; din = 8'(8'h10 + i);
      tick();
    end
    vin = 1'b0; rst = 1'b1;
    tick();
    check_eq("midrst_tdata", 32'(dout), 32'h0);
    rst = 1'b0;
    tick();
    vin = 1'b1; din = 8'hA5;
    tick();
    check_eq("a5_visible", 32'(dout), 32'hA5);
    vin = 1'b0;

    // Watermark path: fill to 12, drain to 3, flush, then reset.
    for (int i = 0; i < 11; i++) begin
      vin = 1'b1; din = 8'(8'h20 + i);
      tick();
    end
    vin = 1'b0; rdy_out = 1'b1;
    repeat (9) tick();
    rdy_out = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Random traffic: stall-heavy first half, drain-heavy second half.
    for (int i = 0; i < 2000; i++) begin
      rst     = ($urandom_range(0, 499) == 0);
      flush   = ($urandom_range(0, 63) == 0);
      vin     = 1'($urandom_range(0, 1));
      din     = 8'($urandom);
      rdy_out = ($urandom_range(0, 3) < ((i < 1000) ? 1 : 3));
      tick();
    end
    rst = 1'b0; flush = 1'b0; vin = 1'b0; rdy_out = 1'b1;
    repeat (20) tick();

    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
